// File: rtl/adc_spi_out_pkg.sv
// Shared types and constants for the SPI frame transmitter.
// Word width, FSM state encoding and the minimum divider setting.
package adc_spi_pkg;

    localparam int WORD_W     = 16;
    localparam int CLKDIV_MIN = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_t;

endpackage

// File: rtl/adc_spi_out_if.sv
// Frame request and SPI pin bundle for adc_spi_out.
// master: transmitter side; slave: requester / receiver side.
interface adc_spi_out_if
    import adc_spi_pkg::*;
#(
    parameter int SENDWORDS = 7
);

    logic                        i_Start;
    logic [WORD_W*SENDWORDS-1:0] i_Words;
    logic                        o_SPI_CS;
    logic                        o_SPI_Clock;
    logic                        o_SPI_Data;
    logic                        o_Busy;
    logic                        o_Done;

    modport master (
        input  i_Start,
        input  i_Words,
        output o_SPI_CS,
        output o_SPI_Clock,
        output o_SPI_Data,
        output o_Busy,
        output o_Done
    );

    modport slave (
        output i_Start,
        output i_Words,
        input  o_SPI_CS,
        input  o_SPI_Clock,
        input  o_SPI_Data,
        input  o_Busy,
        input  o_Done
    );

endinterface

// File: rtl/spi_half_period_tick.sv
// Half-period divider: one-cycle tick every CLKDIV clocks.
// i_Clear restarts the count so each phase starts aligned.
module spi_half_period_tick #(
    parameter int CLKDIV = 4
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] cnt;

    assign o_Tick = (cnt == CW'(CLKDIV - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear || o_Tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_out.sv
// SPI master transmitter: SENDWORDS 16-bit words, MSB first, one CS frame.
// ADC_SPI_OUT_CHECKSUM_EN appends a mod-2^16 sum word to each frame.
module adc_spi_out
    import adc_spi_pkg::*;
#(
    parameter int SENDWORDS = 7,
    parameter int CLKDIV    = 4,
    parameter int CS_GAP    = 8
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    adc_spi_out_if.master bus
);

`ifdef ADC_SPI_OUT_CHECKSUM_EN
    localparam int NW = SENDWORDS + 1;
`else
    localparam int NW = SENDWORDS;
`endif
    localparam int SW  = WORD_W * NW;
    localparam int WCW = $clog2(SENDWORDS + 2);
    localparam int GCW = $clog2(CS_GAP + 1);

    localparam logic [WCW-1:0] LAST_W = WCW'(NW - 1);
    localparam logic [GCW-1:0] LAST_G = GCW'(CS_GAP - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [GCW-1:0]  gcnt_q, gcnt_d;
    logic            fin_q, fin_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            clr;
    logic [SW-1:0]   snap;

    // Word 0 goes to the top of the shift register so it leaves first
    always_comb begin
        snap = '0;
        for (int i = 0; i < SENDWORDS; i++) begin
            snap[(NW-1-i)*WORD_W +: WORD_W] = bus.i_Words[i*WORD_W +: WORD_W];
        end
    end

`ifdef ADC_SPI_OUT_CHECKSUM_EN
    logic [WORD_W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < SENDWORDS; i++) begin
            csum = csum + sreg_q[(NW-1-i)*WORD_W +: WORD_W];
        end
    end
`endif

    assign clr = (state_d != state_q) || (state_q == IDLE);

    spi_half_period_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Clear (clr),
        .o_Tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        fin_d   = fin_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    state_d = SETUP;
                    sreg_d  = snap;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                    fin_d   = 1'b0;
                    cs_d    = 1'b0;
                    data_d  = bus.i_Words[WORD_W-1];
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
`ifdef ADC_SPI_OUT_CHECKSUM_EN
                sreg_d[WORD_W-1:0] = csum;
`endif
                if (tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (tick) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    if (bcnt_q == 4'hF && wcnt_q == LAST_W) begin
                        fin_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                        if (bcnt_q == 4'hF) begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                        sreg_d = {sreg_q[SW-2:0], 1'b0};
                        data_d = sreg_q[SW-2];
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    if (fin_q) begin
                        state_d = GAP;
                        cs_d    = 1'b1;
                        data_d  = 1'b0;
                        gcnt_d  = '0;
                        done_d  = (CS_GAP == 1);
                    end else begin
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == LAST_G) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                    done_d = ((gcnt_q + 1'b1) == LAST_G);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            fin_q   <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            fin_q   <= fin_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_SPI_CS    = cs_q;
    assign bus.o_SPI_Clock = sclk_q;
    assign bus.o_SPI_Data  = data_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Done      = done_q;

endmodule

// File: tb/tb_adc_spi_out.sv
// Directed bench for adc_spi_out with a deglitching receiver model.
// Honours ADC_SPI_OUT_CHECKSUM_EN for frame length and extra word.
module tb_adc_spi_out;
    import adc_spi_pkg::*;

    localparam int SW = 7;
    localparam int CD = 4;
    localparam int GP = 8;
`ifdef ADC_SPI_OUT_CHECKSUM_EN
    localparam int NW = SW + 1;
`else
    localparam int NW = SW;
`endif
    localparam int BUSY_EXP = CD + 32 * NW * CD + GP;
    localparam int PULSE_N  = 1800;
    localparam int FRM_EXP  = (PULSE_N - 1) / (BUSY_EXP + 1) + 1;

    logic i_Clock = 1'b0;
    logic i_Reset;

    always #5 i_Clock = ~i_Clock;

    adc_spi_out_if #(.SENDWORDS(SW)) bus ();

    adc_spi_out #(
        .SENDWORDS (SW),
        .CLKDIV    (CD),
        .CS_GAP    (GP)
    ) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        mon_clr;
    int          busy_cnt, done_cnt, rise_cnt, viol, phase_err;
    int          run, frames, min_gap, cs_hi_run, rx_bits;
    logic        prev_cs, prev_sclk, prev_data, st;
    logic [2:0]  sh;
    logic [15:0] rx_w [16];

    always @(negedge i_Clock) begin
        if (mon_clr) begin
            busy_cnt = 0; done_cnt = 0; rise_cnt = 0;
            viol = 0; phase_err = 0; run = 0;
            frames = 0; min_gap = 99999; cs_hi_run = 0;
            rx_bits = 0; st = 1'b0; sh = 3'b000;
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_data = 1'b0;
            for (int i = 0; i < 16; i++) rx_w[i] = '0;
        end else begin
            if (bus.o_Busy) busy_cnt++;
            if (bus.o_Done) done_cnt++;
            if (!bus.o_SPI_CS) begin
                if (prev_cs) begin
                    if (frames > 0 && cs_hi_run < min_gap) min_gap = cs_hi_run;
                    frames++;
                    cs_hi_run = 0;
                    run = 1;
                    if (bus.o_SPI_Clock) viol++;
                end else begin
                    if (bus.o_SPI_Clock != prev_sclk) begin
                        if (run != CD) phase_err++;
                        run = 1;
                    end else begin
                        run++;
                    end
                    if (prev_sclk && bus.o_SPI_Clock && bus.o_SPI_Data != prev_data) viol++;
                    if (!prev_sclk && bus.o_SPI_Clock) rise_cnt++;
                end
            end else begin
                if (!prev_cs && run != CD) phase_err++;
                if (bus.o_SPI_Clock) viol++;
                cs_hi_run++;
            end
            // Receiver: level accepted only after three equal samples
            sh = {sh[1:0], bus.o_SPI_Clock};
            if (!st && sh == 3'b111) begin
                st = 1'b1;
                if (!bus.o_SPI_CS && rx_bits < 256) begin
                    rx_w[rx_bits/16] = {rx_w[rx_bits/16][14:0], bus.o_SPI_Data};
                    rx_bits++;
                end
            end else if (st && sh == 3'b000) begin
                st = 1'b0;
            end
            prev_cs   = bus.o_SPI_CS;
            prev_sclk = bus.o_SPI_Clock;
            prev_data = bus.o_SPI_Data;
        end
    end

    logic [15:0] tw [SW];
    logic [15:0] ew [8];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic set_words();
        for (int i = 0; i < SW; i++) bus.i_Words[i*16 +: 16] = tw[i];
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        cyc(1);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        cyc(1);
        bus.i_Start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.o_Busy && n < 5000) begin
            cyc(1);
            n++;
        end
        check({tag, "_idle"}, {31'd0, bus.o_Busy}, 32'd0);
        cyc(2);
    endtask

    task automatic frame_checks(input string tag);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s_word%0d", tag, i), {16'd0, rx_w[i]}, {16'd0, ew[i]});
        end
        check({tag, "_busy"}, busy_cnt, BUSY_EXP);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_rises"}, rise_cnt, 16 * NW);
        check({tag, "_viol"}, viol, 0);
        check({tag, "_phase"}, phase_err, 0);
    endtask

    task automatic load_main();
        tw[0] = 16'h8001; tw[1] = 16'h1234; tw[2] = 16'hFFFF;
        tw[3] = 16'h0000; tw[4] = 16'hA5A5; tw[5] = 16'h5A5A;
        tw[6] = 16'h7FFE;
        for (int i = 0; i < SW; i++) ew[i] = tw[i];
        ew[7] = 16'h1231;
        set_words();
    endtask

    initial begin
        i_Reset     = 1'b1;
        mon_clr     = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Words = '0;
        cyc(3);
        i_Reset = 1'b0;
        mon_clr = 1'b0;
        check("rst_cs", {31'd0, bus.o_SPI_CS}, 32'd1);
        check("rst_sclk", {31'd0, bus.o_SPI_Clock}, 32'd0);
        check("rst_data", {31'd0, bus.o_SPI_Data}, 32'd0);
        check("rst_busy", {31'd0, bus.o_Busy}, 32'd0);
        check("rst_done", {31'd0, bus.o_Done}, 32'd0);

        // Main frame; words rewritten one cycle after acceptance
        load_main();
        clear_mon();
        pulse_start();
        for (int i = 0; i < SW; i++) tw[i] = ~tw[i];
        set_words();
        wait_idle("main");
        frame_checks("main");

`ifdef ADC_SPI_OUT_CHECKSUM_EN
        for (int i = 0; i < SW; i++) begin
            tw[i] = 16'hFFFF;
            ew[i] = 16'hFFFF;
        end
        ew[7] = 16'hFFF9;
        set_words();
        clear_mon();
        pulse_start();
        wait_idle("csum");
        frame_checks("csum");
`endif

        // Start held high: one frame per busy window, none queued
        load_main();
        clear_mon();
        bus.i_Start = 1'b1;
        cyc(PULSE_N);
        bus.i_Start = 1'b0;
        wait_idle("burst");
        check("burst_frames", frames, FRM_EXP);
        check("burst_done", done_cnt, FRM_EXP);
        check("burst_rises", rise_cnt, FRM_EXP * 16 * NW);
        check("burst_gap", {31'd0, min_gap >= GP}, 32'd1);
        check("burst_viol", viol, 0);

        // Reset in the middle of a frame
        clear_mon();
        pulse_start();
        cyc(299);
        i_Reset = 1'b1;
        cyc(1);
        check("mid_cs", {31'd0, bus.o_SPI_CS}, 32'd1);
        check("mid_sclk", {31'd0, bus.o_SPI_Clock}, 32'd0);
        check("mid_data", {31'd0, bus.o_SPI_Data}, 32'd0);
        check("mid_busy", {31'd0, bus.o_Busy}, 32'd0);
        i_Reset = 1'b0;
        cyc(20);
        check("mid_nodone", done_cnt, 0);

        load_main();
        clear_mon();
        pulse_start();
        wait_idle("post");
        frame_checks("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
